alu_wb: RTL and testbench

ALU_WB -- requirements
Module: alu_wb

---
 rtl/alu_wb_pkg.sv | 24 ++
 rtl/alu_flags_reg.sv | 30 +++
 rtl/alu_wb.sv | 91 +++++++++
 tb/tb_alu_wb.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU write-back stage.
// Flag vector layout is {HCF,VF,SF,ZF,CF}; bit 0 feeds the ALU carry-in.
package alu_wb_pkg;

  localparam int FLAGS_W  = 5;
  localparam int FLAG_CF  = 0;
  localparam int FLAG_ZF  = 1;
  localparam int FLAG_SF  = 2;
  localparam int FLAG_VF  = 3;
  localparam int FLAG_HCF = 4;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef logic [FLAGS_W-1:0] flags_t;

  // Byte ops replace only the low byte; the high byte comes from the old destination.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic              byte_mode);
    byte_merge = byte_mode ? ((old_v & 16'hFF00) | (new_v & 16'h00FF)) : new_v;
  endfunction

endpackage

// File: rtl/alu_flags_reg.sv
// Architectural flags register. A direct load (POPF/STC/CLC path) beats an ALU flag
// update landing in the same cycle.
module alu_flags_reg
  import alu_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_en_i,
  input  logic [FLAGS_W-1:0] upd_val_i,
  input  logic               set_en_i,
  input  logic [FLAGS_W-1:0] set_val_i,
  output logic [FLAGS_W-1:0] flags_o
);

  flags_t flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (set_en_i)      flags_d = set_val_i;
    else if (upd_en_i) flags_d = upd_val_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/alu_wb.sv
// ALU write-back stage: one-entry register between ALU result and register file,
// plus the flags register. Define ALU_WB_FWD_EN to expose the stage entry as a bypass.
module alu_wb
  import alu_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_q,
  input  logic [FLAGS_W-1:0] in_flags,
  input  logic               in_flag_we,
  input  logic               in_rd_we,
  input  logic [ADDR_W-1:0]  in_rd,
  input  logic [DATA_W-1:0]  in_rd_old,
  input  logic               in_wb,
  input  logic               flag_set_valid,
  input  logic [FLAGS_W-1:0] flag_set,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_addr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic               rf_ready,
`ifdef ALU_WB_FWD_EN
  output logic               fwd_valid,
  output logic [ADDR_W-1:0]  fwd_addr,
  output logic [DATA_W-1:0]  fwd_data,
`endif
  output logic [FLAGS_W-1:0] flags_o
);

  logic              st_valid_q, st_valid_d;
  logic              st_we_q,    st_we_d;
  logic [ADDR_W-1:0] st_addr_q,  st_addr_d;
  logic [DATA_W-1:0] st_data_q,  st_data_d;
  logic              xfer, retire;

  // Entries without a register write never wait on the register file.
  assign in_ready = !st_valid_q || !st_we_q || rf_ready;
  assign xfer     = in_valid && in_ready;
  assign retire   = st_valid_q && (!st_we_q || rf_ready);

  always_comb begin
    st_valid_d = st_valid_q;
    st_we_d    = st_we_q;
    st_addr_d  = st_addr_q;
    st_data_d  = st_data_q;
    if (xfer) begin
      st_valid_d = 1'b1;
      st_we_d    = in_rd_we;
      st_addr_d  = in_rd;
      st_data_d  = byte_merge(in_rd_old, in_q, in_wb);
    end else if (retire) begin
      st_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_q <= 1'b0;
      st_we_q    <= 1'b0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
    end else begin
      st_valid_q <= st_valid_d;
      st_we_q    <= st_we_d;
      st_addr_q  <= st_addr_d;
      st_data_q  <= st_data_d;
    end
  end

  assign rf_we    = st_valid_q && st_we_q;
  assign rf_addr  = st_addr_q;
  assign rf_wdata = st_data_q;

`ifdef ALU_WB_FWD_EN
  assign fwd_valid = st_valid_q && st_we_q;
  assign fwd_addr  = st_addr_q;
  assign fwd_data  = st_data_q;
`endif

  alu_flags_reg u_flags (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_en_i  (xfer && in_flag_we),
    .upd_val_i (in_flags),
    .set_en_i  (flag_set_valid),
    .set_val_i (flag_set),
    .flags_o   (flags_o)
  );

endmodule

// File: tb/tb_alu_wb.sv
// Directed table-driven bench for alu_wb, plus hand sequences for reset-during-stall
// and the optional forwarding outputs.
module tb_alu_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_q, in_rd_old;
  logic [4:0]  in_flags, flag_set, flags_o;
  logic        in_flag_we, in_rd_we, in_wb, flag_set_valid;
  logic [2:0]  in_rd, rf_addr;
  logic        rf_we, rf_ready;
  logic [15:0] rf_wdata;
`ifdef ALU_WB_FWD_EN
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
`endif

  always #5 clk = ~clk;

  alu_wb dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_flags(in_flags),
    .in_flag_we(in_flag_we), .in_rd_we(in_rd_we), .in_rd(in_rd), .in_rd_old(in_rd_old),
    .in_wb(in_wb), .flag_set_valid(flag_set_valid), .flag_set(flag_set),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
`ifdef ALU_WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`endif
    .flags_o(flags_o)
  );

  typedef struct {
    logic        vld;  logic [15:0] q;   logic [4:0] fl; logic flwe;
    logic        we;   logic [2:0]  rd;  logic [15:0] old; logic wb;
    logic        fsv;  logic [4:0]  fs;  logic rdy;
    logic        x_rdy; logic x_we;  logic [2:0] x_addr; logic [15:0] x_data; logic [4:0] x_fl;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [15:0] q, input logic [4:0] fl,
                              input logic flwe, input logic we, input logic [2:0] rd,
                              input logic [15:0] old, input logic wb, input logic fsv,
                              input logic [4:0] fs, input logic rdy, input logic x_rdy,
                              input logic x_we, input logic [2:0] x_addr,
                              input logic [15:0] x_data, input logic [4:0] x_fl);
    vec_t v;
    v.vld = vld; v.q = q; v.fl = fl; v.flwe = flwe; v.we = we; v.rd = rd; v.old = old;
    v.wb = wb; v.fsv = fsv; v.fs = fs; v.rdy = rdy; v.x_rdy = x_rdy; v.x_we = x_we;
    v.x_addr = x_addr; v.x_data = x_data; v.x_fl = x_fl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = v.vld; in_q = v.q; in_flags = v.fl; in_flag_we = v.flwe; in_rd_we = v.we;
    in_rd = v.rd; in_rd_old = v.old; in_wb = v.wb; flag_set_valid = v.fsv;
    flag_set = v.fs; rf_ready = v.rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(mk(0, 16'h0, 5'h0, 0, 0, 3'd0, 16'h0, 0, 0, 5'h0, rdy, 0, 0, 3'd0, 16'h0, 5'h0));
  endtask

  initial begin
    // vld q fl flwe we rd old wb fsv fs rdy | x_rdy(pre-edge) x_we x_addr x_data x_fl
    tbl.push_back(mk(1,16'h1234,5'h00,0,1,3'd3,16'h0000,0,0,5'h00,1, 1,1,3'd3,16'h1234,5'h00));
    tbl.push_back(mk(1,16'h00AB,5'h05,1,1,3'd2,16'h5566,1,0,5'h00,1, 1,1,3'd2,16'h55AB,5'h05));
    tbl.push_back(mk(0,16'h0000,5'h00,0,0,3'd0,16'h0000,0,0,5'h00,1, 1,0,3'd0,16'h0000,5'h05));
    tbl.push_back(mk(1,16'hFFFF,5'h10,1,0,3'd7,16'h0000,0,0,5'h00,1, 1,0,3'd0,16'h0000,5'h10));
    tbl.push_back(mk(1,16'h0F0F,5'h00,0,1,3'd1,16'h0000,0,0,5'h00,0, 1,1,3'd1,16'h0F0F,5'h10));
    tbl.push_back(mk(1,16'h2222,5'h1F,1,1,3'd4,16'h0000,0,0,5'h00,0, 0,1,3'd1,16'h0F0F,5'h10));
    tbl.push_back(mk(1,16'h2222,5'h1F,1,1,3'd4,16'h0000,0,0,5'h00,0, 0,1,3'd1,16'h0F0F,5'h10));
    tbl.push_back(mk(1,16'h2222,5'h1F,1,1,3'd4,16'h0000,0,1,5'h03,0, 0,1,3'd1,16'h0F0F,5'h03));
    tbl.push_back(mk(1,16'h2222,5'h1F,1,1,3'd4,16'h0000,0,0,5'h00,1, 1,1,3'd4,16'h2222,5'h1F));
    tbl.push_back(mk(1,16'h3333,5'h01,1,1,3'd6,16'h0000,0,1,5'h06,1, 1,1,3'd6,16'h3333,5'h06));
    tbl.push_back(mk(1,16'h4444,5'h1F,0,1,3'd0,16'hAAAA,0,0,5'h00,1, 1,1,3'd0,16'h4444,5'h06));
    tbl.push_back(mk(0,16'h0000,5'h00,0,0,3'd0,16'h0000,0,0,5'h00,1, 1,0,3'd0,16'h0000,5'h06));

    rst_n = 1'b0;
    idle(1'b1);
    repeat (2) @(negedge clk);
    nvec++;
    chk("reset rf_we", rf_we, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset flags", flags_o, 0);
    chk("reset rf_addr", rf_addr, 0);
    chk("reset rf_wdata", rf_wdata, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      nvec++;
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, tbl[i].x_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rf_we", i), rf_we, tbl[i].x_we);
      if (tbl[i].x_we) begin
        chk($sformatf("v%0d rf_addr", i), rf_addr, tbl[i].x_addr);
        chk($sformatf("v%0d rf_wdata", i), rf_wdata, tbl[i].x_data);
      end
      chk($sformatf("v%0d flags", i), flags_o, tbl[i].x_fl);
    end

    // Write to r5 accepted, then stalled behind a second op; reset hits mid-stall.
    @(negedge clk);
    drive(mk(1,16'hBEEF,5'h0A,1,1,3'd5,16'h0000,0,0,5'h00,1, 0,0,3'd0,16'h0,5'h0));
    @(posedge clk);
    #1;
    nvec++;
    chk("fwd-op rf_we", rf_we, 1);
    chk("fwd-op rf_addr", rf_addr, 5);
    chk("fwd-op rf_wdata", rf_wdata, 16'hBEEF);
    chk("fwd-op flags", flags_o, 5'h0A);
`ifdef ALU_WB_FWD_EN
    chk("fwd_valid", fwd_valid, 1);
    chk("fwd_addr", fwd_addr, 5);
    chk("fwd_data", fwd_data, 16'hBEEF);
`endif
    @(negedge clk);
    drive(mk(1,16'h7777,5'h1F,1,1,3'd2,16'h0000,0,0,5'h00,0, 0,0,3'd0,16'h0,5'h0));
    #1;
    nvec++;
    chk("stall in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("stall rf_we", rf_we, 1);
    chk("stall rf_addr", rf_addr, 5);
    chk("stall rf_wdata", rf_wdata, 16'hBEEF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++;
    chk("rst-stall rf_we", rf_we, 0);
    chk("rst-stall flags", flags_o, 0);
    chk("rst-stall in_ready", in_ready, 1);
    @(negedge clk);
    idle(1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      nvec++;
      chk($sformatf("post-rst rf_we c%0d", k), rf_we, 0);
      chk($sformatf("post-rst flags c%0d", k), flags_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
